seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumer of the 480 Hz refresh square wave produced by the board's refresh clock divider.
- Time-multiplexes a 32-bit hex value onto the Nexys 4 eight-digit common-anode 7-segment display.
- Per refresh edge it advances one digit, drives that digit's anode low, and presents the decoded cathode pattern.
- Supports:
  - frame-coherent data snapshot;
  - per-digit blanking;
  - decimal points;
  - optional leading-zero suppression;
  - an anti-ghosting dark interval between digits.

Parameters:
- BLANK_CYCLES, 4: clk_in cycles all anodes are held off after each digit change; 0 disables the dark interval.

Ports:
- clk_in  input  1  100 MHz board clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- refresh_in  input  1  refresh square wave from the divider, synchronous to clk_in; only rising edges are used.
- data_in  input  32  eight hex nibbles; data_in[3:0] is digit 0 (rightmost).
- blank_in  input  8  per-digit force-blank; 1 = digit dark.
- dp_in  input  8  per-digit decimal point; 1 = lit.
- lz_en  input  1  1 = suppress leading zeros.
- an  output  8  anodes, active-low; an[0] is digit 0.
- seg  output  7  cathodes, active-low; seg[6:0] = {a,b,c,d,e,f,g}.
- dp  output  1  decimal-point cathode, active-low.

Behaviour:
- Reset (async, dominates everything):
  - an=8'hFF, seg=7'h7F, dp=1.
  - digit_sel=0, started=0, refresh_q=0, blank_cnt=0.
  - Snapshot registers = 0.
- Edge detect:
  - refresh_q registers refresh_in every cycle.
  - rise = refresh_in & ~refresh_q.
  - A level held high produces exactly one rise.
- First rise after reset (started=0):
  - Set started=1.
  - Load snapshot of data_in, blank_in, dp_in and lz_en.
  - digit_sel stays 0.
- Later rises:
  - digit_sel <= digit_sel+1 mod 8, wrapping 7->0.
  - On the 7->0 transition the snapshot reloads in the same cycle.
  - Input changes mid-frame are invisible until the next wrap.
- Dark interval:
  - On every rise, blank_cnt <= BLANK_CYCLES.
  - It decrements each cycle while nonzero and saturates at 0.
  - A rise arriving during the interval reloads the counter and still advances digit_sel.
- Digit visibility: digit d is visible iff all of the following hold:
  - started=1;
  - blank_cnt==0;
  - snapshot blank[d]==0;
  - not leading-suppressed.
- Leading-zero suppression (snapshot lz=1 only):
  - Digit d is suppressed iff d>0 and nibbles d..7 are all zero.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Output registers, updated every cycle from the current digit_sel, snapshot and blank_cnt:
  - an = ~(8'b1 << digit_sel) when visible, else 8'hFF.
  - seg = decode(nibble) when visible, else 7'h7F.
  - dp = ~snapshot dp[digit_sel] when visible, else 1.
  - Latency: a rise sampled at clock edge N updates digit_sel at N; an/seg/dp reflect it at N+1.
  - With BLANK_CYCLES=B>0, the first lit cycle of the new digit is N+B+1.
- Decode, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Invariant: at most one an bit is low in any cycle.
- Reset asserted mid-scan: outputs go dark asynchronously. After release, the display stays dark until the next rise, then restarts at digit 0 with a fresh snapshot.

Test Plan:
- Reset release, refresh_in held 0 for 1000 cycles -> an=FF, seg=7F, dp=1 throughout.
- data_in=32'h76543210, blank=0, dp=0, lz=0, BLANK_CYCLES=4, 9 rises -> digits 0,1,…,7,0 in order:
  - each an is one-hot low;
  - seg follows the decode table (digit 0 = 0000001, digit 7 = 0001111);
  - an=FF for exactly 4 cycles after each rise.
- Rise cycle timing -> an/seg/dp update on the cycle after the rise is sampled, then are held through the dark interval.
- data_in=32'h0000_00A0, lz=1 -> digits 7..2 dark (an=FF in their slots); digit 1 seg=0001000; digit 0 seg=0000001.
- data_in=32'h0, lz=1 -> only digit 0 lit, showing 0000001.
- dp_in=8'h10, blank_in=8'h02 -> dp=0 only in the digit-4 slot; digit 1 slot dark.
- Change data_in at digit 3 from 32'h11111111 to 32'h22222222 -> digits 4..7 still show "1" (1001111); "2" (0010010) appears only after the wrap to 0.
- Two rises 2 cycles apart with BLANK_CYCLES=4 -> digit_sel advances twice; the counter reloads on the second rise; the second new digit lights 5 cycles after the second rise.
- Assert reset for 1 cycle at digit 5 -> an=FF immediately; the next rise shows digit 0 from the new snapshot.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed driver for a common-anode 7-segment display.
// Advances one digit per rising refresh edge and shows a frame-coherent snapshot of the inputs.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        refresh_in,
  input  logic [31:0] data_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(BLANK_CYCLES);

  logic            refresh_q;
  logic            rise;
  logic            started_q, started_d;
  logic [2:0]      digit_sel_q, digit_sel_d;
  logic [CntW-1:0] blank_cnt_q, blank_cnt_d;
  logic            load_snap;
  logic [31:0]     snap_data_q, snap_data_d;
  logic [7:0]      snap_blank_q, snap_blank_d;
  logic [7:0]      snap_dp_q, snap_dp_d;
  logic            snap_lz_q, snap_lz_d;
  logic [3:0]      nibble;
  logic [6:0]      seg_dec;
  logic            upper_zero;
  logic            suppressed;
  logic            visible;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  assign rise = refresh_in & ~refresh_q;

  // The first rise only arms the scan; digit 0 is shown without advancing.
  always_comb begin
    started_d   = started_q;
    digit_sel_d = digit_sel_q;
    load_snap   = 1'b0;
    if (rise) begin
      if (!started_q) begin
        started_d = 1'b1;
        load_snap = 1'b1;
      end else begin
        digit_sel_d = digit_sel_q + 3'd1;
        load_snap   = (digit_sel_q == 3'd7);
      end
    end
    snap_data_d  = load_snap ? data_in  : snap_data_q;
    snap_blank_d = load_snap ? blank_in : snap_blank_q;
    snap_dp_d    = load_snap ? dp_in    : snap_dp_q;
    snap_lz_d    = load_snap ? lz_en    : snap_lz_q;
  end

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (rise) begin
      blank_cnt_d = CntLoad;
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - 1'b1;
    end
  end

  assign nibble = snap_data_q[{digit_sel_q, 2'b00} +: 4];

  // Zero-check of the current nibble and every more significant one.
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(digit_sel_q) && snap_data_q[4*k +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign suppressed = snap_lz_q && (digit_sel_q != 3'd0) && upper_zero;
  assign visible    = started_q && (blank_cnt_q == '0) && !snap_blank_q[digit_sel_q]
                      && !suppressed;

  always_comb begin
    case (nibble)
      4'h0:    seg_dec = 7'b0000001;
      4'h1:    seg_dec = 7'b1001111;
      4'h2:    seg_dec = 7'b0010010;
      4'h3:    seg_dec = 7'b0000110;
      4'h4:    seg_dec = 7'b1001100;
      4'h5:    seg_dec = 7'b0100100;
      4'h6:    seg_dec = 7'b0100000;
      4'h7:    seg_dec = 7'b0001111;
      4'h8:    seg_dec = 7'b0000000;
      4'h9:    seg_dec = 7'b0000100;
      4'hA:    seg_dec = 7'b0001000;
      4'hB:    seg_dec = 7'b1100000;
      4'hC:    seg_dec = 7'b0110001;
      4'hD:    seg_dec = 7'b1000010;
      4'hE:    seg_dec = 7'b0110000;
      default: seg_dec = 7'b0111000;
    endcase
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~(8'b1 << digit_sel_q);
      seg_d = seg_dec;
      dp_d  = ~snap_dp_q[digit_sel_q];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      refresh_q    <= 1'b0;
      started_q    <= 1'b0;
      digit_sel_q  <= 3'd0;
      blank_cnt_q  <= '0;
      snap_data_q  <= 32'h0;
      snap_blank_q <= 8'h0;
      snap_dp_q    <= 8'h0;
      snap_lz_q    <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      refresh_q    <= refresh_in;
      started_q    <= started_d;
      digit_sel_q  <= digit_sel_d;
      blank_cnt_q  <= blank_cnt_d;
      snap_data_q  <= snap_data_d;
      snap_blank_q <= snap_blank_d;
      snap_dp_q    <= snap_dp_d;
      snap_lz_q    <= snap_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a vector table of single-digit snapshots plus
// hand-written sequences for timing, mid-frame updates, back-to-back rises and reset.
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        refresh_in = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  blank_in = 8'h0;
  logic [7:0]  dp_in = 8'h0;
  logic        lz_en = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_pass = 0;

  localparam logic [6:0] Dec [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  dpv;
    logic        lz;
    int          digit;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [21];

  seg7_scan_driver #(.BLANK_CYCLES(4)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .refresh_in (refresh_in),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    refresh_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One refresh pulse, then wait until the new digit has left the dark interval.
  task automatic rise_and_settle();
    refresh_in = 1'b1;
    tick();
    refresh_in = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int bad;
    logic [7:0] exp_an;

    vecs[0]  = '{32'h76543210, 8'h00, 8'h00, 1'b0, 0, 8'hFE, 7'b0000001, 1'b1};
    vecs[1]  = '{32'h76543210, 8'h00, 8'h00, 1'b0, 3, 8'hF7, 7'b0000110, 1'b1};
    vecs[2]  = '{32'h76543210, 8'h00, 8'h00, 1'b0, 6, 8'hBF, 7'b0100000, 1'b1};
    vecs[3]  = '{32'h76543210, 8'h00, 8'h00, 1'b0, 7, 8'h7F, 7'b0001111, 1'b1};
    vecs[4]  = '{32'h000000A0, 8'h00, 8'h00, 1'b1, 0, 8'hFE, 7'b0000001, 1'b1};
    vecs[5]  = '{32'h000000A0, 8'h00, 8'h00, 1'b1, 1, 8'hFD, 7'b0001000, 1'b1};
    vecs[6]  = '{32'h000000A0, 8'h00, 8'h00, 1'b1, 2, 8'hFF, 7'h7F,      1'b1};
    vecs[7]  = '{32'h000000A0, 8'h00, 8'h00, 1'b1, 7, 8'hFF, 7'h7F,      1'b1};
    vecs[8]  = '{32'h00000000, 8'h00, 8'h00, 1'b1, 0, 8'hFE, 7'b0000001, 1'b1};
    vecs[9]  = '{32'h00000000, 8'h00, 8'h00, 1'b1, 1, 8'hFF, 7'h7F,      1'b1};
    vecs[10] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 4, 8'hEF, 7'b1100000, 1'b0};
    vecs[11] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 1, 8'hFF, 7'h7F,      1'b1};
    vecs[12] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 5, 8'hDF, 7'b0001000, 1'b1};
    vecs[13] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 0, 8'hFE, 7'b0111000, 1'b1};
    vecs[14] = '{32'h00000A05, 8'h00, 8'h00, 1'b1, 1, 8'hFD, 7'b0000001, 1'b1};
    vecs[15] = '{32'h00000A05, 8'h00, 8'h00, 1'b1, 3, 8'hFF, 7'h7F,      1'b1};
    vecs[16] = '{32'h00000A05, 8'h00, 8'h00, 1'b0, 3, 8'hF7, 7'b0000001, 1'b1};
    vecs[17] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 2, 8'hFB, 7'b1000010, 1'b1};
    vecs[18] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 3, 8'hF7, 7'b0110001, 1'b1};
    vecs[19] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 6, 8'hBF, 7'b0000100, 1'b1};
    vecs[20] = '{32'h89ABCDEF, 8'h02, 8'h10, 1'b0, 7, 8'h7F, 7'b0000000, 1'b1};

    // Idle after reset: dark throughout.
    do_reset();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) bad++;
      tick();
    end
    check("idle_dark_cycles", bad, 0);

    // Table: scan to a digit from a fresh snapshot and compare its slot.
    for (int i = 0; i < 21; i++) begin
      do_reset();
      data_in  = vecs[i].data;
      blank_in = vecs[i].blank;
      dp_in    = vecs[i].dpv;
      lz_en    = vecs[i].lz;
      rise_and_settle();
      for (int d = 0; d < vecs[i].digit; d++) rise_and_settle();
      check($sformatf("vec%0d_an", i), an, vecs[i].an);
      check($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
      check($sformatf("vec%0d_dp", i), dp, vecs[i].dp);
    end

    // Full scan with wrap: four dark cycles after each rise, then the next digit.
    do_reset();
    data_in = 32'h76543210; blank_in = 8'h00; dp_in = 8'h00; lz_en = 1'b0;
    for (int r = 0; r < 9; r++) begin
      refresh_in = 1'b1;
      tick();
      refresh_in = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        check($sformatf("scan_r%0d_dark%0d", r, k), an, 8'hFF);
      end
      tick();
      exp_an = ~(8'h01 << (r % 8));
      check($sformatf("scan_r%0d_an", r), an, exp_an);
      check($sformatf("scan_r%0d_seg", r), seg, Dec[r % 8]);
      check($sformatf("scan_r%0d_onehot", r), $countones(~an), 1);
    end

    // Mid-frame data change stays invisible until the wrap.
    do_reset();
    data_in = 32'h11111111;
    rise_and_settle();
    check("midframe_d0", seg, 7'b1001111);
    repeat (3) rise_and_settle();
    data_in = 32'h22222222;
    for (int d = 4; d < 8; d++) begin
      rise_and_settle();
      check($sformatf("midframe_d%0d_seg", d), seg, 7'b1001111);
    end
    rise_and_settle();
    check("midframe_wrap_an", an, 8'hFE);
    check("midframe_wrap_seg", seg, 7'b0010010);

    // Two rises two cycles apart: both advance, the second reloads the dark counter.
    do_reset();
    data_in = 32'h76543210;
    rise_and_settle();
    refresh_in = 1'b1;
    tick();
    refresh_in = 1'b0;
    tick();
    refresh_in = 1'b1;
    tick();
    refresh_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("b2b_dark%0d", k), an, 8'hFF);
    end
    tick();
    check("b2b_an", an, 8'hFB);
    check("b2b_seg", seg, 7'b0010010);

    // A level held high counts as one rise.
    do_reset();
    rise_and_settle();
    refresh_in = 1'b1;
    repeat (20) tick();
    refresh_in = 1'b0;
    tick();
    check("level_once_an", an, 8'hFD);

    // Reset mid-scan goes dark at once and restarts from a fresh snapshot.
    do_reset();
    data_in = 32'h76543210;
    repeat (6) rise_and_settle();
    check("rst_pre_an", an, 8'hDF);
    reset = 1'b1;
    #1;
    check("rst_async_an", an, 8'hFF);
    check("rst_async_seg", seg, 7'h7F);
    check("rst_async_dp", dp, 1'b1);
    tick();
    reset = 1'b0;
    data_in = 32'h00000003;
    repeat (20) tick();
    check("rst_wait_dark", an, 8'hFF);
    rise_and_settle();
    check("rst_restart_an", an, 8'hFE);
    check("rst_restart_seg", seg, 7'b0000110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
